// File: rtl/kbd_pkg.sv
// Shared types and constants for the keyboard MMIO block.
package kbd_pkg;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_event_t;

  localparam logic [7:0] KBD_PFX_EXT = 8'hE0;
  localparam logic [7:0] KBD_PFX_BRK = 8'hF0;

  localparam logic [3:0] KBD_REG_DATA   = 4'h0;
  localparam logic [3:0] KBD_REG_STATUS = 4'h4;
  localparam logic [3:0] KBD_REG_CTRL   = 4'h8;

  // Map a decoded cur_key word onto a compact event.
  function automatic kbd_event_t kbd_decode(input logic [31:0] key);
    kbd_event_t ev;
    ev.code = key[7:0];
    ev.brk  = (key[15:8] == KBD_PFX_BRK);
    ev.ext  = (key[15:8] == KBD_PFX_EXT) || (key[23:16] == KBD_PFX_EXT);
    return ev;
  endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Key event FIFO: power-of-two depth, synchronous flush, pop of empty and
// push of full (without a same-cycle pop) are ignored.
module kbd_event_fifo
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  kbd_event_t    data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_next_o,
  output kbd_event_t    head_o
);

  kbd_event_t          mem_q [DEPTH];
  logic       [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic       [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic       [CW-1:0] count_q, count_d;
  logic                do_push, do_pop;

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CW'(DEPTH));
  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign head_o       = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next-state pointers and occupancy; flush overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy gates every read of it.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/kbd_mmio.sv
// Keyboard event queue with DATA/STATUS/CTRL registers.
// Optional feature: define KBD_MMIO_IRQ_EN to enable the interrupt output and
// the CTRL[2] irq_en bit; otherwise kbd_irq is tied low and CTRL reads 0.
module kbd_mmio
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] cur_key,
  input  logic        bus_re,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        kbd_irq
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0] prev_key_q;
  logic [31:0] rdata_q, rdata_d;
  logic        ovf_q, ovf_d;
  logic        irq_en;

  logic          evt_valid;
  kbd_event_t    evt;
  logic [3:0]    reg_addr;
  logic          rd_en, wr_ctrl;
  logic          pop, flush, ovf_clr, overflow;
  logic          full, empty;
  logic [CW-1:0] count, count_next;
  kbd_event_t    head;

  assign evt_valid = (cur_key != prev_key_q) && (cur_key != '0);
  assign evt       = kbd_decode(cur_key);

  assign reg_addr = {bus_addr[3:2], 2'b00};
  // A simultaneous write suppresses the read entirely.
  assign rd_en    = bus_re && !bus_we;
  assign wr_ctrl  = bus_we && (reg_addr == KBD_REG_CTRL);
  assign pop      = rd_en && (reg_addr == KBD_REG_DATA) && !empty;
  assign flush    = wr_ctrl && bus_wdata[0];
  assign ovf_clr  = wr_ctrl && bus_wdata[1];
  assign overflow = evt_valid && full && !pop && !flush;

  kbd_event_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (clrn),
    .push_i      (evt_valid),
    .data_i      (evt),
    .pop_i       (pop),
    .flush_i     (flush),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count),
    .count_next_o(count_next),
    .head_o      (head)
  );

  // Overflow set beats a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (overflow)     ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Read data mux; rdata holds between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      unique case (reg_addr)
        KBD_REG_DATA:   if (!empty) rdata_d = {1'b1, 21'b0, head};
        KBD_REG_STATUS: rdata_d = {16'b0, 8'(count), 5'b0, full, ovf_q, !empty};
        KBD_REG_CTRL:   rdata_d = {29'b0, irq_en, 2'b00};
        default:        rdata_d = '0;
      endcase
    end
  end

  // Key history, overflow flag and read data registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      prev_key_q <= '0;
      ovf_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      prev_key_q <= cur_key;
      ovf_q      <= ovf_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus_rdata = rdata_q;

`ifdef KBD_MMIO_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  // irq follows the post-edge state so it tracks pushes and flushes immediately.
  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_ctrl) irq_en_d = bus_wdata[2];
    irq_d = irq_en_d && ((count_next != '0) || ovf_d);
  end

  // Interrupt enable and request registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en  = irq_en_q;
  assign kbd_irq = irq_q;

  logic unused_sig;
  assign unused_sig = ^{bus_addr[1:0], bus_wdata[31:3], cur_key[31:24]};
`else
  assign irq_en  = 1'b0;
  assign kbd_irq = 1'b0;

  logic unused_sig;
  assign unused_sig = ^{bus_addr[1:0], bus_wdata[31:2], cur_key[31:24], count_next};
`endif

endmodule
